// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared types and defaults for the fetch PC sequencer: state encoding,
// PC width, reset PC and flush length.
package fetch_pc_sequencer_pkg;

  localparam int PC_W  = 8;
  localparam int CNT_W = 3;

  localparam logic [PC_W-1:0] DEF_RESET_PC     = 8'h00;
  localparam int              DEF_FLUSH_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Word-addressed increment; wraps 8'hFF -> 8'h00 silently.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] p);
    return p + {{(PC_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fetch_pc_sequencer_flush_timer.sv
// Down-counter that times the flush window after a redirect.
// done is high in the last cycle of the window (count == 1).
module flush_timer
  import fetch_pc_sequencer_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign done = (count == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC sequencer: increments the word-addressed PC, applies taken-branch
// redirects (deferred while stalled) and raises flush for the wrong-path window.
module fetch_pc_sequencer
  import fetch_pc_sequencer_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC     = DEF_RESET_PC,
  parameter int              FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            br_valid,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_next,
  output logic            flush,
  output logic            redirect_pending
);

  // FLUSH_CYCLES is legal in 1..7, so it always fits the 3-bit timer.
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

  state_e          state, state_d;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pend, pend_d;
  logic            timer_load;
  logic            timer_done;
  logic            taken;

  assign taken   = br_valid & br_taken;
  assign pc_next = pc_inc(pc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      pc    <= RESET_PC;
      pend  <= '0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      pend  <= pend_d;
    end
  end

  always_comb begin
    state_d    = state;
    pc_d       = pc;
    pend_d     = pend;
    timer_load = 1'b0;
    case (state)
      ST_RUN: begin
        if (taken && stall) begin
          pend_d  = br_target;
          state_d = ST_HOLD;
        end else if (taken) begin
          pc_d       = br_target;
          state_d    = ST_FLUSH;
          timer_load = 1'b1;
        end else if (!stall) begin
          pc_d = pc_next;
        end
      end
      ST_HOLD: begin
        // First captured target wins; later branches are ignored here.
        if (!stall) begin
          pc_d       = pend;
          state_d    = ST_FLUSH;
          timer_load = 1'b1;
        end
      end
      ST_FLUSH: begin
        // Timer runs regardless of stall; branch inputs are wrong-path.
        if (!stall) begin
          pc_d = pc_next;
        end
        if (timer_done) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  flush_timer #(
    .W(CNT_W)
  ) u_flush_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (FLUSH_LOAD),
    .done     (timer_done)
  );

  assign flush            = (state == ST_FLUSH);
  assign redirect_pending = (state == ST_HOLD);

endmodule
